ntt_input_packer: RTL and testbench

NTT_INPUT_PACKER -- requirements
Module: ntt_input_packer

---
 rtl/ntt_input_packer.sv | 184 ++++++++++++++++++
 tb/tb_ntt_input_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_input_packer.sv
// ntt_input_packer
// Collects a natural-order coefficient stream into two ping-pong banks of
// ROWS_PER_POLY x INPUT_PER_CYCLE words.  A full bank is then emitted as
// ROWS_PER_POLY back-to-back rows, with a replicated start pulse on row 0.
module ntt_input_packer #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int ROWS_PER_POLY        = 16
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic                                                    s_valid,
   output logic                                                    s_ready,
   input  logic [DATA_WIDTH_PER_INPUT-1:0]                         s_data,
   input  logic                                                    s_last,
   output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]    out_data,
   output logic                                                    out_valid,
   output logic [7:0]                                              out_start,
   output logic                                                    err_last
);

   localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
   localparam int ROW_W  = $clog2(ROWS_PER_POLY);
   localparam int CNT_W  = LANE_W + ROW_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [ROW_W-1:0] ROW_MAX = {ROW_W{1'b1}};

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   bank_state_t                                            bank_st_r [2];
   bank_state_t                                            bank_nx_s [2];
   logic                                                   wptr_r;
   logic                                                   wptr_nx_s;
   logic                                                   rptr_r;
   logic                                                   rptr_nx_s;
   logic [CNT_W-1:0]                                       wcnt_r;
   logic [ROW_W-1:0]                                       drow_r;
   logic [ROW_W-1:0]                                       drow_nx_s;
   logic                                                   s_ready_r;
   logic                                                   ready_nx_s;
   logic                                                   out_valid_r;
   logic [7:0]                                             out_start_r;
   logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   out_data_r;
   logic                                                   err_last_r;
   logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   mem_r [2*ROWS_PER_POLY];
   logic                                                   xfer_s;
   logic                                                   wr_last_s;
   logic                                                   drain_start_s;
   logic                                                   drain_step_s;
   logic                                                   drain_bank_s;
   logic [ROW_W:0]                                         rd_addr_s;
   logic [ROW_W:0]                                         wr_addr_s;
   logic [LANE_W-1:0]                                      wr_lane_s;

   assign s_ready   = s_ready_r;
   assign out_valid = out_valid_r;
   assign out_start = out_start_r;
   assign out_data  = out_data_r;
   assign err_last  = err_last_r;

   // Next-state of both banks, pointers and the drain sequencer.
   always_comb begin
      bank_nx_s[0]  = bank_st_r[0];
      bank_nx_s[1]  = bank_st_r[1];
      wptr_nx_s     = wptr_r;
      rptr_nx_s     = rptr_r;
      drain_start_s = 1'b0;
      drain_step_s  = 1'b0;
      drain_bank_s  = rptr_r;
      drow_nx_s     = drow_r + ROW_W'(1);
      xfer_s        = s_valid & s_ready_r;
      wr_last_s     = (wcnt_r == CNT_MAX);
      wr_lane_s     = wcnt_r[LANE_W-1:0];
      wr_addr_s     = {wptr_r, wcnt_r[CNT_W-1:LANE_W]};

      // Write side: only ever touches an EMPTY or FILLING bank.
      if (xfer_s) begin
         if (wr_last_s) begin
            bank_nx_s[wptr_r] = BANK_FULL;
            wptr_nx_s         = ~wptr_r;
         end else begin
            bank_nx_s[wptr_r] = BANK_FILLING;
         end
      end else begin
         wptr_nx_s = wptr_r;
      end

      // Read side: only ever touches a FULL or DRAINING bank.
      if (out_valid_r && (drow_r != ROW_MAX)) begin
         drain_step_s = 1'b1;
      end else if (out_valid_r) begin
         // Last row is on the output now: free the bank, chain if the other is ready.
         bank_nx_s[rptr_r] = BANK_EMPTY;
         rptr_nx_s         = ~rptr_r;
         if (bank_st_r[~rptr_r] == BANK_FULL) begin
            drain_start_s      = 1'b1;
            drain_bank_s       = ~rptr_r;
            bank_nx_s[~rptr_r] = BANK_DRAINING;
         end else begin
            drain_start_s = 1'b0;
         end
      end else if (bank_st_r[rptr_r] == BANK_FULL) begin
         drain_start_s     = 1'b1;
         drain_bank_s      = rptr_r;
         bank_nx_s[rptr_r] = BANK_DRAINING;
      end else begin
         drain_start_s = 1'b0;
      end

      if (drain_start_s) begin
         rd_addr_s = {drain_bank_s, {ROW_W{1'b0}}};
      end else begin
         rd_addr_s = {rptr_r, drow_nx_s};
      end

      ready_nx_s = (bank_nx_s[wptr_nx_s] == BANK_EMPTY) ||
                   (bank_nx_s[wptr_nx_s] == BANK_FILLING);
   end

   // Coefficient storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (xfer_s) begin
         mem_r[wr_addr_s][wr_lane_s] <= s_data;
      end
   end

   // Control state, write counter, framing error flag and registered row outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_st_r[0] <= BANK_EMPTY;
         bank_st_r[1] <= BANK_EMPTY;
         wptr_r       <= 1'b0;
         rptr_r       <= 1'b0;
         wcnt_r       <= '0;
         drow_r       <= '0;
         s_ready_r    <= 1'b0;
         out_valid_r  <= 1'b0;
         out_start_r  <= 8'h00;
         out_data_r   <= '0;
         err_last_r   <= 1'b0;
      end else begin
         bank_st_r[0] <= bank_nx_s[0];
         bank_st_r[1] <= bank_nx_s[1];
         wptr_r       <= wptr_nx_s;
         rptr_r       <= rptr_nx_s;
         s_ready_r    <= ready_nx_s;

         // Framing errors are only flagged; counting continues unchanged.
         if (xfer_s) begin
            wcnt_r <= wcnt_r + CNT_W'(1);
            if (s_last != wr_last_s) begin
               err_last_r <= 1'b1;
            end else begin
               err_last_r <= err_last_r;
            end
         end else begin
            wcnt_r <= wcnt_r;
         end

         if (drain_start_s) begin
            drow_r      <= '0;
            out_valid_r <= 1'b1;
            out_start_r <= 8'hFF;
            out_data_r  <= mem_r[rd_addr_s];
         end else if (drain_step_s) begin
            drow_r      <= drow_nx_s;
            out_valid_r <= 1'b1;
            out_start_r <= 8'h00;
            out_data_r  <= mem_r[rd_addr_s];
         end else begin
            drow_r      <= '0;
            out_valid_r <= 1'b0;
            out_start_r <= 8'h00;
            out_data_r  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ntt_input_packer.sv
// Bench for ntt_input_packer: table of whole-polynomial scenarios plus
// hand-written back-to-back, reset-during-drain and idle sequences.
module tb_ntt_input_packer;

   logic                    clk;
   logic                    rst;
   logic                    s_valid;
   logic                    s_ready;
   logic [27:0]             s_data;
   logic                    s_last;
   logic [31:0][27:0]       out_data;
   logic                    out_valid;
   logic [7:0]              out_start;
   logic                    err_last;

   ntt_input_packer dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_start (out_start),
      .err_last  (err_last)
   );

   typedef struct {
      logic [27:0] base;
      logic        descend;
      int          pct;
      int          last_pos;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [5];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [27:0] sb [$];
   logic        mon_en     = 1'b0;
   int          row_idx    = 0;
   logic        prev_valid = 1'b0;
   int          rows_seen  = 0;
   int          start_cyc  = -1;
   int          end_cyc    = -1;
   logic [27:0] mon_act;
   logic [27:0] mon_exp;
   logic [27:0] mon_e;
   logic        mon_bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter, read at negedges as the index of the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor: each row must equal the next 32 accepted words in order.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            check("out_start", out_start, (row_idx == 0) ? 8'hFF : 8'h00);
            if (row_idx != 0) check("burst_gap", prev_valid, 1'b1);
            if (sb.size() < 32) begin
               check("row_underflow", sb.size(), 32);
            end else begin
               mon_bad = 1'b0;
               mon_act = out_data[0];
               mon_exp = sb[0];
               for (int l = 0; l < 32; l++) begin
                  mon_e = sb.pop_front();
                  if (!mon_bad && out_data[l] !== mon_e) begin
                     mon_bad = 1'b1;
                     mon_act = out_data[l];
                     mon_exp = mon_e;
                  end
               end
               check("row_data", mon_act, mon_exp);
            end
            if (row_idx == 0) start_cyc = cyc;
            if (row_idx == 15) end_cyc = cyc;
            row_idx = (row_idx + 1) % 16;
            rows_seen++;
         end else begin
            check("idle_zero", {out_start, |out_data, (row_idx != 0)}, 64'h0);
         end
         prev_valid = out_valid;
      end
   end

   task automatic do_reset();
      mon_en  = 1'b0;
      rst     = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 28'h0;
      repeat (3) @(negedge clk);
      check("reset_state", {s_ready, out_valid, out_start, err_last, |out_data}, 64'h0);
      sb.delete();
      row_idx    = 0;
      prev_valid = 1'b0;
      rst        = 1'b1;
      check("ready_before_edge", s_ready, 1'b0);
      @(negedge clk);
      check("ready_after_edge", s_ready, 1'b1);
      mon_en = 1'b1;
   endtask

   task automatic send_word(input logic [27:0] d, input logic l, input int pct,
                            output int t, inout int stalls);
      int g;
      g = 0;
      while (pct < 100 && $urandom_range(99) >= pct && g < 8) begin
         s_valid = 1'b0;
         @(negedge clk);
         g++;
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      g = 0;
      while (!s_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      stalls += g;
      t = cyc;
      if (!s_ready) begin
         check("ready_timeout", s_ready, 1'b1);
      end else begin
         sb.push_back(d);
         @(negedge clk);
      end
   endtask

   task automatic wait_rows(input int target);
      for (int k = 0; k < 300 && rows_seen < target; k++) @(negedge clk);
      check("rows_emitted", rows_seen, target);
   endtask

   initial begin
      int          t_last;
      int          stalls;
      int          r0;
      logic [27:0] d;

      rst     = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 28'h0;

      vecs[0] = '{base: 28'h0000000, descend: 1'b0, pct: 100, last_pos: 511, exp_err: 1'b0};
      vecs[1] = '{base: 28'h0000000, descend: 1'b0, pct: 50,  last_pos: 511, exp_err: 1'b0};
      vecs[2] = '{base: 28'h0ABC000, descend: 1'b0, pct: 100, last_pos: 511, exp_err: 1'b0};
      vecs[3] = '{base: 28'h0000000, descend: 1'b1, pct: 70,  last_pos: 511, exp_err: 1'b0};
      vecs[4] = '{base: 28'h0000000, descend: 1'b0, pct: 100, last_pos: 100, exp_err: 1'b1};

      // Table: one polynomial per record, checking data, latency and framing flag.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         r0     = rows_seen;
         stalls = 0;
         t_last = 0;
         for (int i = 0; i < 512; i++) begin
            d = vecs[v].descend ? (28'hFFFFFFF - 28'(i)) : (vecs[v].base + 28'(i));
            send_word(d, (i == vecs[v].last_pos), vecs[v].pct, t_last, stalls);
            check("err_last_word", err_last, (vecs[v].last_pos != 511) && (i >= vecs[v].last_pos));
         end
         s_valid = 1'b0;
         s_last  = 1'b0;
         wait_rows(r0 + 16);
         check("start_latency", start_cyc, t_last + 2);
         check("row15_latency", end_cyc, t_last + 17);
         check("err_last_final", err_last, vecs[v].exp_err);
      end

      // Back-to-back: four polynomials with s_valid held high, no stalls allowed.
      do_reset();
      r0     = rows_seen;
      stalls = 0;
      for (int i = 0; i < 2048; i++) begin
         send_word(28'(i * 3), ((i % 512) == 511), 100, t_last, stalls);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("b2b_stalls", stalls, 0);
      wait_rows(r0 + 64);
      check("b2b_err_last", err_last, 1'b0);

      // Reset during row 7 of a drain while the second bank is filling.
      do_reset();
      stalls = 0;
      for (int i = 0; i < 512; i++) begin
         send_word(28'(i), (i == 511), 100, t_last, stalls);
      end
      for (int i = 0; i < 8; i++) begin
         send_word(28'h0100000 + 28'(i), 1'b0, 100, r0, stalls);
      end
      check("mid_drain_valid", out_valid, 1'b1);
      check("mid_drain_row7", out_data[0], 28'd224);
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_zero", {s_ready, out_valid, out_start, err_last, |out_data}, 64'h0);
      do_reset();
      r0 = rows_seen;
      for (int i = 0; i < 512; i++) begin
         send_word(28'h0005000 + 28'(i), (i == 511), 100, t_last, stalls);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      wait_rows(r0 + 16);
      check("post_reset_start", start_cyc, t_last + 2);
      check("post_reset_err", err_last, 1'b0);

      // Idle input: outputs stay quiet.
      do_reset();
      r0 = rows_seen;
      repeat (40) @(negedge clk);
      check("idle_no_rows", rows_seen, r0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
